ibuffer_warp_queue: RTL and testbench
=====================================

Name: ibuffer_warp_queue

Overview:
- Per-warp instruction buffer, successor to the fixed two-entry warp buffer.
- Parametrised depth and payload width; accepts up to two decoded instructions per cycle from the dual decoder; issues the head to the issue unit.
- Adds in-buffer memory-replay tracking: LW/SW heads are retained after issue until MEM feedback retires all active threads.
- Adds selective flush on SIMT drop.

Parameters:
- DEPTH, 4, entry count; power of 2, >=2
- IW, 64, packed decoded-instruction payload width (opaque to this block)
- NUM_THREADS, 8, active-mask width
- CW, $clog2(DEPTH+1), occupancy count width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- valid_id0  in  1  deposit slot 0 valid
- payload_id0  in  IW  slot 0 decoded instruction
- mem_id0  in  1  slot 0 is LW/SW (replayable)
- valid_id1  in  1  deposit slot 1 valid; legal only with valid_id0
- payload_id1  in  IW  slot 1 decoded instruction
- mem_id1  in  1  slot 1 is LW/SW
- am_simt  in  NUM_THREADS  active mask captured with each deposit
- req_if  out  1  request next fetch pair
- drop_simt  in  1  flush (taken branch / divergence)
- req_iu  out  1  head issuable
- grt_iu  in  1  head granted this cycle
- head_payload  out  IW  head instruction
- head_am  out  NUM_THREADS  head remaining active mask
- head_first  out  1  head not yet issued (scoreboard allocates entry only when 1)
- head_mem  out  1  head is replayable
- pos_fb_valid  in  1  positive MEM feedback for this warp
- pos_fb  in  NUM_THREADS  threads served
- zero_fb_valid  in  1  miss served, head may re-issue
- replay_complete  out  1  one-cycle pulse: replayable head retired
- count  out  CW  occupancy
- overflow  out  1  sticky: deposit arrived with no free slot

Behaviour:
- Reset (async): pointers, count=0, head state IDLE, all outputs 0 except req_if=1 (DEPTH>=2 free). Payload storage is not reset; head_payload don't-care while count==0.
- Circular FIFO with wr/rd pointers wrapping mod DEPTH.
  - Deposit order: slot 0, then slot 1.
  - A deposit is visible at head one cycle after the edge that writes it.
- req_if = (DEPTH-count >= 2), evaluated after this cycle's pop.
- Deposit into a full slot is dropped and sets overflow. Overflow clears only on rst.
- Head state machine:
  - IDLE: head ready, never issued.
  - WAIT_FB: mem head issued, awaiting feedback.
  - REPLAY: re-issuable.
- req_iu = (count>0) && state!=WAIT_FB.
- head_first = (state==IDLE). head_am = remaining mask (initialised from captured am_simt).
- grt_iu with req_iu:
  - Non-mem head: pop on that edge.
  - Mem head: no pop; go to WAIT_FB.
- grt_iu while req_iu=0: ignored.
- In WAIT_FB:
  - pos_fb_valid: remaining <= remaining & ~pos_fb.
    - Result 0: pop, pulse replay_complete next cycle, state IDLE for the new head.
    - Result nonzero: stay in WAIT_FB unless zero_fb_valid is also asserted.
  - zero_fb_valid (alone, or with pos leaving nonzero): go to REPLAY.
  - Pos and zero in the same cycle: pos applied first; if remaining becomes 0, retire and ignore zero.
- Feedback outside WAIT_FB: ignored.
- REPLAY + grt_iu: go to WAIT_FB, no pop.
- drop_simt:
  - Discards all entries behind the head; count becomes 1 if the head is in WAIT_FB/REPLAY, else 0.
  - Same-cycle deposits are discarded.
  - Same-cycle grt_iu on a non-mem head is a pop, so the queue is empty.
- Simultaneous pop and deposit of two: count += 1. Space is evaluated against post-pop occupancy.

Test Plan:
- Reset, deposit pair A(mem=0), B(mem=0) with am=8'hFF -> next cycle count=2, req_iu=1, head=A, head_first=1; grt_iu -> head=B, count=1.
- DEPTH=4: deposit two pairs with no grant -> count=4, req_if=0; a third pair -> dropped, overflow=1 stays set.
- Mem head am=8'hFF, grt_iu -> req_iu=0; pos_fb=8'h0F -> head_am=8'hF0, state WAIT_FB; zero_fb -> req_iu=1, head_first=0; grt_iu then pos_fb=8'hF0 -> pop, replay_complete pulses one cycle.
- pos_fb=8'hFF and zero_fb_valid together on a WAIT_FB head -> retire, no REPLAY, replay_complete=1.
- Three entries with head in WAIT_FB, drop_simt plus deposit pair -> count=1, head retained, later pos_fb retires it -> count=0.
- Assert rst mid-WAIT_FB with count=3 -> immediately count=0, req_iu=0, req_if=1, overflow=0; later feedback ignored.

Source files
------------

// File: rtl/ibuffer_warp_queue_if.sv
// Bundle of the decoder-deposit, issue-unit and MEM-feedback signals of one warp's
// instruction buffer; slave is the buffer, master is whoever drives it.
interface ibuffer_warp_queue_if #(
  parameter int IW          = 64,
  parameter int NUM_THREADS = 8,
  parameter int CW          = 3
);
  logic                   valid_id0;
  logic [IW-1:0]          payload_id0;
  logic                   mem_id0;
  logic                   valid_id1;
  logic [IW-1:0]          payload_id1;
  logic                   mem_id1;
  logic [NUM_THREADS-1:0] am_simt;
  logic                   req_if;
  logic                   drop_simt;
  logic                   req_iu;
  logic                   grt_iu;
  logic [IW-1:0]          head_payload;
  logic [NUM_THREADS-1:0] head_am;
  logic                   head_first;
  logic                   head_mem;
  logic                   pos_fb_valid;
  logic [NUM_THREADS-1:0] pos_fb;
  logic                   zero_fb_valid;
  logic                   replay_complete;
  logic [CW-1:0]          count;
  logic                   overflow;

  modport master (
    output valid_id0, payload_id0, mem_id0, valid_id1, payload_id1, mem_id1,
           am_simt, drop_simt, grt_iu, pos_fb_valid, pos_fb, zero_fb_valid,
    input  req_if, req_iu, head_payload, head_am, head_first, head_mem,
           replay_complete, count, overflow
  );

  modport slave (
    input  valid_id0, payload_id0, mem_id0, valid_id1, payload_id1, mem_id1,
           am_simt, drop_simt, grt_iu, pos_fb_valid, pos_fb, zero_fb_valid,
    output req_if, req_iu, head_payload, head_am, head_first, head_mem,
           replay_complete, count, overflow
  );
endinterface

// File: rtl/ibuffer_warp_queue.sv
// Per-warp circular instruction buffer: dual-slot deposit, head issue, memory-replay
// tracking of LW/SW heads until every active thread is served, and SIMT-drop flush.
module ibuffer_warp_queue #(
  parameter int DEPTH       = 4,
  parameter int IW          = 64,
  parameter int NUM_THREADS = 8,
  parameter int CW          = $clog2(DEPTH + 1)
) (
  input logic                clk,
  input logic                rst,
  ibuffer_warp_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_FB, REPLAY} head_state_t;

  head_state_t state, state_next;

  logic [IW-1:0]          payload_mem [DEPTH];
  logic [NUM_THREADS-1:0] am_mem      [DEPTH];
  logic [DEPTH-1:0]       mem_flag;

  logic [AW-1:0] rd_ptr, wr_ptr, rd_ptr_next, wr_ptr_next;
  logic [CW-1:0] count_q, count_next, count_post_pop, free_post;
  logic          overflow_q, overflow_now, replay_q;
  logic          nonempty, head_is_mem, issue_fire, pop_issue, pop_retire, pop;
  logic          head_kept, acc0, acc1;
  logic [NUM_THREADS-1:0] head_rem, rem_after_pos;

  always_comb begin
    nonempty       = (count_q != '0);
    head_is_mem    = mem_flag[rd_ptr];
    head_rem       = am_mem[rd_ptr];
    rem_after_pos  = head_rem & ~bus.pos_fb;
    issue_fire     = nonempty && (state != WAIT_FB) && bus.grt_iu;
    pop_issue      = issue_fire && !head_is_mem;
    pop_retire     = (state == WAIT_FB) && bus.pos_fb_valid && (rem_after_pos == '0);
    pop            = pop_issue || pop_retire;
    count_post_pop = count_q - CW'(pop);
    free_post      = CW'(DEPTH) - count_post_pop;
    acc0           = bus.valid_id0 && !bus.drop_simt && (free_post >= CW'(1));
    acc1           = bus.valid_id0 && bus.valid_id1 && !bus.drop_simt && (free_post >= CW'(2));
    overflow_now   = bus.valid_id0 && !bus.drop_simt && (!acc0 || (bus.valid_id1 && !acc1));
  end

  // Positive feedback is applied before zero feedback, so a full retire wins over replay.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (issue_fire && head_is_mem) state_next = WAIT_FB;
      WAIT_FB: if (pop_retire) state_next = IDLE;
               else if (bus.zero_fb_valid) state_next = REPLAY;
      REPLAY:  if (issue_fire) state_next = WAIT_FB;
      default: state_next = IDLE;
    endcase
  end

  // A drop keeps only an in-flight memory head, including one issued on this very edge.
  always_comb begin
    head_kept   = (state_next != IDLE);
    rd_ptr_next = rd_ptr + AW'(pop);
    if (bus.drop_simt) begin
      count_next  = CW'(head_kept);
      wr_ptr_next = rd_ptr_next + AW'(head_kept);
    end else begin
      count_next  = count_post_pop + CW'(acc0) + CW'(acc1);
      wr_ptr_next = wr_ptr + AW'(acc0) + AW'(acc1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      replay_q   <= 1'b0;
    end else begin
      state      <= state_next;
      rd_ptr     <= rd_ptr_next;
      wr_ptr     <= wr_ptr_next;
      count_q    <= count_next;
      overflow_q <= overflow_q || overflow_now;
      replay_q   <= pop_retire;
    end
  end

  // Storage is left unreset; deposits only ever target free slots, never the live head.
  always_ff @(posedge clk) begin
    if (state == WAIT_FB && bus.pos_fb_valid && !pop_retire)
      am_mem[rd_ptr] <= rem_after_pos;
    if (acc0) begin
      payload_mem[wr_ptr] <= bus.payload_id0;
      am_mem[wr_ptr]      <= bus.am_simt;
      mem_flag[wr_ptr]    <= bus.mem_id0;
    end
    if (acc1) begin
      payload_mem[wr_ptr + AW'(1)] <= bus.payload_id1;
      am_mem[wr_ptr + AW'(1)]      <= bus.am_simt;
      mem_flag[wr_ptr + AW'(1)]    <= bus.mem_id1;
    end
  end

  always_comb begin
    bus.req_if          = (free_post >= CW'(2));
    bus.req_iu          = nonempty && (state != WAIT_FB);
    bus.head_first      = nonempty && (state == IDLE);
    bus.head_payload    = payload_mem[rd_ptr];
    bus.head_am         = nonempty ? head_rem : '0;
    bus.head_mem        = nonempty && head_is_mem;
    bus.replay_complete = replay_q;
    bus.count           = count_q;
    bus.overflow        = overflow_q;
  end
endmodule

// File: tb/tb_ibuffer_warp_queue.sv
// Scenario-driven bench for ibuffer_warp_queue: a queue of expected entries is filled on
// deposit and drained/compared whenever the buffer issues or retires its head.
module tb_ibuffer_warp_queue;
  localparam int DEPTH = 4;
  localparam int IW    = 64;
  localparam int NT    = 8;
  localparam int CW    = 3;

  typedef struct {
    logic [IW-1:0] payload;
    logic [NT-1:0] am;
    logic          mem;
  } entry_t;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  entry_t sb[$];
  entry_t exp_e;
  int     n_checks = 0;
  int     n_fail = 0;

  ibuffer_warp_queue_if #(.IW(IW), .NUM_THREADS(NT), .CW(CW)) bus ();

  ibuffer_warp_queue #(.DEPTH(DEPTH), .IW(IW), .NUM_THREADS(NT), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus.valid_id0 = 0; bus.valid_id1 = 0; bus.mem_id0 = 0; bus.mem_id1 = 0;
    bus.payload_id0 = '0; bus.payload_id1 = '0; bus.am_simt = '0;
    bus.drop_simt = 0; bus.grt_iu = 0; bus.pos_fb_valid = 0; bus.pos_fb = '0;
    bus.zero_fb_valid = 0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  // Drives one deposit and records what the buffer should accept (no same-cycle pop).
  task automatic deposit(input logic v1, input logic [IW-1:0] p0, input logic m0,
                         input logic [IW-1:0] p1, input logic m1, input logic [NT-1:0] am);
    entry_t e;
    bus.valid_id0 = 1; bus.payload_id0 = p0; bus.mem_id0 = m0;
    bus.valid_id1 = v1; bus.payload_id1 = p1; bus.mem_id1 = m1;
    bus.am_simt = am;
    if (!bus.drop_simt) begin
      if (sb.size() < DEPTH) begin
        e.payload = p0; e.am = am; e.mem = m0; sb.push_back(e);
      end
      if (v1 && sb.size() < DEPTH) begin
        e.payload = p1; e.am = am; e.mem = m1; sb.push_back(e);
      end
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    n_checks++; if (bus.count !== 3'd0) begin n_fail++; $display("[TB] FAIL reset_count got %0d want 0", bus.count); end
    n_checks++; if (bus.req_if !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_req_if got %b want 1", bus.req_if); end
    n_checks++; if (bus.req_iu !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_req_iu got %b want 0", bus.req_iu); end
    n_checks++; if (bus.head_first !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_head_first got %b want 0", bus.head_first); end
    n_checks++; if (bus.overflow !== 1'b0 || bus.replay_complete !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_flags got ovf=%b rc=%b want 0 0", bus.overflow, bus.replay_complete); end
  endtask

  task automatic test_basic_pair();
    deposit(1, 64'hAAAA_0001, 0, 64'hBBBB_0002, 0, 8'hFF);
    cycle();
    n_checks++; if (bus.count !== 3'd2) begin n_fail++; $display("[TB] FAIL pair_count got %0d want 2", bus.count); end
    n_checks++; if (bus.req_iu !== 1'b1 || bus.head_first !== 1'b1) begin n_fail++; $display("[TB] FAIL pair_head_flags got req_iu=%b first=%b want 1 1", bus.req_iu, bus.head_first); end
    repeat (2) begin
      exp_e = sb.pop_front();
      n_checks++; if (bus.head_payload !== exp_e.payload || bus.head_am !== exp_e.am || bus.head_mem !== exp_e.mem) begin
        n_fail++; $display("[TB] FAIL pair_issue got %h/%h/%b want %h/%h/%b", bus.head_payload, bus.head_am, bus.head_mem, exp_e.payload, exp_e.am, exp_e.mem);
      end
      bus.grt_iu = 1;
      cycle();
      n_checks++; if (bus.count !== CW'(sb.size())) begin n_fail++; $display("[TB] FAIL pair_count_after_grant got %0d want %0d", bus.count, sb.size()); end
    end
  endtask

  task automatic test_overflow();
    deposit(1, 64'hC0, 0, 64'hD0, 0, 8'h0F);
    cycle();
    deposit(1, 64'hE0, 0, 64'hF0, 0, 8'hF0);
    cycle();
    n_checks++; if (bus.count !== 3'd4 || bus.req_if !== 1'b0) begin n_fail++; $display("[TB] FAIL full_state got count=%0d req_if=%b want 4 0", bus.count, bus.req_if); end
    n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("[TB] FAIL full_no_overflow got %b want 0", bus.overflow); end
    deposit(1, 64'h11, 0, 64'h22, 0, 8'h01);
    cycle();
    cycle();
    n_checks++; if (bus.overflow !== 1'b1 || bus.count !== 3'd4) begin n_fail++; $display("[TB] FAIL overflow_sticky got ovf=%b count=%0d want 1 4", bus.overflow, bus.count); end
    while (sb.size() > 0) begin
      exp_e = sb.pop_front();
      n_checks++; if (bus.head_payload !== exp_e.payload || bus.head_am !== exp_e.am) begin
        n_fail++; $display("[TB] FAIL drain_issue got %h/%h want %h/%h", bus.head_payload, bus.head_am, exp_e.payload, exp_e.am);
      end
      bus.grt_iu = 1;
      cycle();
    end
    n_checks++; if (bus.count !== 3'd0 || bus.req_iu !== 1'b0 || bus.overflow !== 1'b1) begin n_fail++; $display("[TB] FAIL drained got count=%0d req_iu=%b ovf=%b want 0 0 1", bus.count, bus.req_iu, bus.overflow); end
  endtask

  task automatic test_mem_replay();
    deposit(1, 64'h4D4D, 1, 64'h4E4E, 0, 8'hFF);
    cycle();
    n_checks++; if (bus.head_mem !== 1'b1 || bus.head_payload !== sb[0].payload) begin n_fail++; $display("[TB] FAIL mem_head got mem=%b payload=%h want 1 %h", bus.head_mem, bus.head_payload, sb[0].payload); end
    bus.grt_iu = 1;
    cycle();
    n_checks++; if (bus.req_iu !== 1'b0 || bus.head_first !== 1'b0 || bus.count !== 3'd2) begin n_fail++; $display("[TB] FAIL wait_fb got req_iu=%b first=%b count=%0d want 0 0 2", bus.req_iu, bus.head_first, bus.count); end
    bus.grt_iu = 1;
    cycle();
    n_checks++; if (bus.req_iu !== 1'b0 || bus.count !== 3'd2) begin n_fail++; $display("[TB] FAIL grant_ignored got req_iu=%b count=%0d want 0 2", bus.req_iu, bus.count); end
    bus.pos_fb_valid = 1; bus.pos_fb = 8'h0F;
    cycle();
    sb[0].am = sb[0].am & ~8'h0F;
    n_checks++; if (bus.head_am !== sb[0].am || bus.req_iu !== 1'b0) begin n_fail++; $display("[TB] FAIL partial_pos got am=%h req_iu=%b want %h 0", bus.head_am, bus.req_iu, sb[0].am); end
    bus.zero_fb_valid = 1;
    cycle();
    n_checks++; if (bus.req_iu !== 1'b1 || bus.head_first !== 1'b0 || bus.head_am !== sb[0].am) begin n_fail++; $display("[TB] FAIL replay got req_iu=%b first=%b am=%h want 1 0 %h", bus.req_iu, bus.head_first, bus.head_am, sb[0].am); end
    bus.grt_iu = 1;
    cycle();
    n_checks++; if (bus.req_iu !== 1'b0 || bus.count !== 3'd2) begin n_fail++; $display("[TB] FAIL reissue got req_iu=%b count=%0d want 0 2", bus.req_iu, bus.count); end
    bus.pos_fb_valid = 1; bus.pos_fb = 8'hF0;
    cycle();
    exp_e = sb.pop_front();
    n_checks++; if (bus.replay_complete !== 1'b1 || bus.count !== 3'd1) begin n_fail++; $display("[TB] FAIL retire got rc=%b count=%0d want 1 1", bus.replay_complete, bus.count); end
    n_checks++; if (bus.head_payload !== sb[0].payload || bus.head_am !== sb[0].am || bus.head_first !== 1'b1) begin n_fail++; $display("[TB] FAIL next_head got %h/%h/%b want %h/%h/1", bus.head_payload, bus.head_am, bus.head_first, sb[0].payload, sb[0].am); end
    cycle();
    n_checks++; if (bus.replay_complete !== 1'b0) begin n_fail++; $display("[TB] FAIL rc_pulse got %b want 0", bus.replay_complete); end
    exp_e = sb.pop_front();
    bus.grt_iu = 1;
    cycle();
    n_checks++; if (bus.count !== 3'd0) begin n_fail++; $display("[TB] FAIL replay_drain got %0d want 0", bus.count); end
  endtask

  task automatic test_pos_zero_same();
    deposit(0, 64'h5050, 1, 64'h0, 0, 8'hFF);
    cycle();
    bus.pos_fb_valid = 1; bus.pos_fb = 8'hFF; bus.zero_fb_valid = 1;
    cycle();
    n_checks++; if (bus.head_am !== 8'hFF || bus.count !== 3'd1 || bus.head_first !== 1'b1) begin n_fail++; $display("[TB] FAIL fb_idle_ignored got am=%h count=%0d first=%b want ff 1 1", bus.head_am, bus.count, bus.head_first); end
    bus.grt_iu = 1;
    cycle();
    bus.pos_fb_valid = 1; bus.pos_fb = 8'hFF; bus.zero_fb_valid = 1;
    cycle();
    exp_e = sb.pop_front();
    n_checks++; if (bus.count !== 3'd0 || bus.replay_complete !== 1'b1 || bus.req_iu !== 1'b0) begin n_fail++; $display("[TB] FAIL pos_zero_retire got count=%0d rc=%b req_iu=%b want 0 1 0", bus.count, bus.replay_complete, bus.req_iu); end
    cycle();
  endtask

  task automatic test_drop();
    deposit(1, 64'h7001, 1, 64'h7002, 0, 8'h33);
    cycle();
    deposit(0, 64'h7003, 0, 64'h0, 0, 8'h33);
    cycle();
    n_checks++; if (bus.count !== 3'd3) begin n_fail++; $display("[TB] FAIL drop_fill got %0d want 3", bus.count); end
    bus.grt_iu = 1;
    cycle();
    bus.drop_simt = 1;
    deposit(1, 64'h7777, 0, 64'h8888, 0, 8'hFF);
    cycle();
    while (sb.size() > 1) sb.pop_back();
    n_checks++; if (bus.count !== 3'd1 || bus.req_iu !== 1'b0 || bus.head_payload !== sb[0].payload) begin n_fail++; $display("[TB] FAIL drop_keep got count=%0d req_iu=%b head=%h want 1 0 %h", bus.count, bus.req_iu, bus.head_payload, sb[0].payload); end
    bus.pos_fb_valid = 1; bus.pos_fb = 8'h33;
    cycle();
    exp_e = sb.pop_front();
    n_checks++; if (bus.count !== 3'd0 || bus.replay_complete !== 1'b1) begin n_fail++; $display("[TB] FAIL drop_retire got count=%0d rc=%b want 0 1", bus.count, bus.replay_complete); end
    deposit(1, 64'h9001, 0, 64'h9002, 0, 8'h01);
    cycle();
    bus.drop_simt = 1;
    cycle();
    sb.delete();
    n_checks++; if (bus.count !== 3'd0 || bus.req_iu !== 1'b0) begin n_fail++; $display("[TB] FAIL drop_idle got count=%0d req_iu=%b want 0 0", bus.count, bus.req_iu); end
  endtask

  task automatic test_reset_mid();
    deposit(1, 64'hA1, 1, 64'hA2, 0, 8'hFF);
    cycle();
    deposit(0, 64'hA3, 0, 64'h0, 0, 8'hFF);
    cycle();
    bus.grt_iu = 1;
    cycle();
    n_checks++; if (bus.count !== 3'd3 || bus.req_iu !== 1'b0) begin n_fail++; $display("[TB] FAIL pre_reset got count=%0d req_iu=%b want 3 0", bus.count, bus.req_iu); end
    #2 rst = 1;
    #1;
    sb.delete();
    n_checks++; if (bus.count !== 3'd0 || bus.req_iu !== 1'b0 || bus.req_if !== 1'b1 || bus.overflow !== 1'b0) begin
      n_fail++; $display("[TB] FAIL async_reset got count=%0d req_iu=%b req_if=%b ovf=%b want 0 0 1 0", bus.count, bus.req_iu, bus.req_if, bus.overflow);
    end
    cycle();
    rst = 0;
    bus.pos_fb_valid = 1; bus.pos_fb = 8'hFF; bus.zero_fb_valid = 1;
    cycle();
    cycle();
    n_checks++; if (bus.count !== 3'd0 || bus.replay_complete !== 1'b0 || bus.req_iu !== 1'b0) begin n_fail++; $display("[TB] FAIL post_reset_fb got count=%0d rc=%b req_iu=%b want 0 0 0", bus.count, bus.replay_complete, bus.req_iu); end
  endtask

  initial begin
    test_reset();
    test_basic_pair();
    test_overflow();
    test_mem_replay();
    test_pos_zero_same();
    test_drop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
